// File: rtl/instruction_fetch_pkg.sv
// Shared CPU package: opcode constants, fetch FSM encoding and the reset instruction.
// The decoder and control FSM import the same definitions.
package instruction_fetch_pkg;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_JMP = 4'b1000;
  localparam logic [3:0] OP_JZ  = 4'b1001;
  localparam logic [3:0] OP_HLT = 4'b1101;

  // Reset value of the instruction register; the decoder also treats it as HLT.
  localparam logic [15:0] RESET_INSTR = {OP_HLT, 12'h000};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_HI  = 2'd1,
    RD_LO  = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  function automatic logic is_hlt(input logic [7:0] opcode_byte);
    return opcode_byte[7:4] == OP_HLT;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Bus between the control FSM / ROM side (master) and the fetch unit (slave).
// fetch_en is a request the fetch unit samples only while IDLE; instr_valid is a
// one-cycle pulse with no back-pressure, and pc_load redirects at any point before HALTED.
interface instruction_fetch_if #(
  parameter int PC_W = 8
);
  logic            fetch_en;
  logic            pc_load;
  logic [PC_W-1:0] pc_target;
  logic [7:0]      rom_data;
  logic [PC_W-1:0] rom_addr;
  logic [15:0]     Fetch;
  logic            instr_valid;
  logic [PC_W-1:0] pc;
  logic            halted;

  modport master (
    output fetch_en, pc_load, pc_target, rom_data,
    input  rom_addr, Fetch, instr_valid, pc, halted
  );

  modport slave (
    input  fetch_en, pc_load, pc_target, rom_data,
    output rom_addr, Fetch, instr_valid, pc, halted
  );
endinterface

// File: rtl/instruction_fetch.sv
// Two-byte big-endian instruction fetch from a synchronous byte ROM.
// Reads the opcode byte, then the operand byte, and stops for good on HLT.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  instruction_fetch_if.slave   bus,
  output fetch_state_t         state_dbg
);

  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(1);

  fetch_state_t    state;
  logic [PC_W-1:0] pc_q;
  logic [15:0]     fetch_q;
  logic [7:0]      hi_byte;
  logic            instr_valid_q;
  logic            halted_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      pc_q          <= RESET_PC;
      fetch_q       <= RESET_INSTR;
      hi_byte       <= 8'h00;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      instr_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.pc_load) begin
            pc_q <= bus.pc_target & ALIGN_MASK;
          end else if (bus.fetch_en) begin
            state <= RD_HI;
          end
        end
        RD_HI: begin
          if (bus.pc_load) begin
            pc_q  <= bus.pc_target & ALIGN_MASK;
            state <= IDLE;
          end else begin
            hi_byte <= bus.rom_data;
            state   <= RD_LO;
          end
        end
        RD_LO: begin
          if (bus.pc_load) begin
            pc_q  <= bus.pc_target & ALIGN_MASK;
            state <= IDLE;
          end else begin
            fetch_q       <= {hi_byte, bus.rom_data};
            instr_valid_q <= 1'b1;
            pc_q          <= pc_q + PC_W'(2);
            // halted rises together with the HLT instruction's valid pulse
            if (is_hlt(hi_byte)) begin
              halted_q <= 1'b1;
              state    <= HALTED;
            end else begin
              state <= IDLE;
            end
          end
        end
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

  // The ROM registers the address, so RD_HI already points at the low byte.
  assign bus.rom_addr    = (state == RD_HI) ? pc_q + PC_W'(1) : pc_q;
  assign bus.Fetch       = fetch_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.pc          = pc_q;
  assign bus.halted      = halted_q;
  assign state_dbg       = state;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  localparam int PC_W = 8;

  logic         clk;
  logic         reset;
  fetch_state_t state_dbg;

  instruction_fetch_if #(.PC_W(PC_W)) bus ();

  instruction_fetch #(.PC_W(PC_W), .RESET_PC(8'h00)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- synchronous ROM ----------------
  logic [7:0] rom [256];
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  // ---------------- reference model ----------------
  // A fetch is a transaction: it starts when an idle unit accepts fetch_en, and
  // two clocks later the instruction {rom[a], rom[a+1]} appears unless redirected.
  int          total = 0;
  int          bad   = 0;
  bit          chk_en = 1'b0;
  logic [15:0] exp_q[$];

  bit          m_pending;
  int          m_age;
  logic [7:0]  m_addr;
  logic [7:0]  m_pc;
  logic [15:0] m_fetch;
  bit          m_valid;
  bit          m_halted;

  always @(posedge clk) begin
    if (reset) begin
      m_pending = 0; m_age = 0; m_addr = 8'h00; m_pc = 8'h00;
      m_fetch = 16'hD000; m_valid = 0; m_halted = 0;
    end else begin
      m_valid = 0;
      if (!m_halted) begin
        if (bus.pc_load) begin
          m_pc      = bus.pc_target & 8'hFE;
          m_pending = 0;
        end else if (m_pending && m_age == 1) begin
          m_fetch   = {rom[m_addr], rom[m_addr + 8'd1]};
          m_valid   = 1;
          m_pc      = m_addr + 8'd2;
          m_halted  = (rom[m_addr] >> 4) == 8'h0D;
          m_pending = 0;
          exp_q.push_back(m_fetch);
        end else if (m_pending) begin
          m_age = 1;
        end else if (bus.fetch_en) begin
          m_pending = 1;
          m_age     = 0;
          m_addr    = m_pc;
        end
      end
    end
  end

  function automatic fetch_state_t model_state();
    if (m_halted)  return HALTED;
    if (m_pending) return (m_age == 0) ? RD_HI : RD_LO;
    return IDLE;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  logic [15:0] exp_instr;
  always @(negedge clk) begin
    if (chk_en) begin
      check("pc",          32'(bus.pc),          32'(m_pc));
      check("fetch_reg",   32'(bus.Fetch),       32'(m_fetch));
      check("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
      check("halted",      32'(bus.halted),      32'(m_halted));
      check("rom_addr",    32'(bus.rom_addr),
            32'((m_pending && m_age == 0) ? m_pc + 8'd1 : m_pc));
      check("state",       32'(state_dbg),       32'(model_state()));
      if (bus.instr_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_instr", 32'(bus.Fetch), 32'hFFFF_FFFF);
        end else begin
          exp_instr = exp_q.pop_front();
          check("instr_stream", 32'(bus.Fetch), 32'(exp_instr));
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input bit rst, input bit fe, input bit pl, input logic [7:0] tgt);
    reset         = rst;
    bus.fetch_en  = fe;
    bus.pc_load   = pl;
    bus.pc_target = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_rom();
    logic [7:0] b;
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom_range(0, 255));
      // keep HLT opcodes rare so random runs do useful work between resets
      if (i % 2 == 0 && b[7:4] == 4'hD && $urandom_range(0, 3) != 0) b[7:4] = 4'h1;
      rom[i] = b;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; bus.fetch_en = 1'b0; bus.pc_load = 1'b0; bus.pc_target = 8'h00;
    randomize_rom();
    rom[0] = 8'h01; rom[1] = 8'h48; rom[2] = 8'h5A; rom[3] = 8'h11;
    rom[4] = 8'h23; rom[5] = 8'h45;
    rom[8'h20] = 8'h3C; rom[8'h21] = 8'h7E;
    rom[8'hFE] = 8'h1A; rom[8'hFF] = 8'h5B;

    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    chk_en = 1'b1;
    check("reset_fetch", 32'(bus.Fetch), 32'hD000);
    check("reset_pc",    32'(bus.pc), 32'h00);
    check("reset_addr",  32'(bus.rom_addr), 32'h00);
    check("reset_valid", 32'(bus.instr_valid), 32'h0);
    check("reset_halt",  32'(bus.halted), 32'h0);

    // single fetch
    step(0, 1, 0, 8'h00);
    check("single_addr_lo", 32'(bus.rom_addr), 32'h01);
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    check("single_fetch", 32'(bus.Fetch), 32'h0148);
    check("single_valid", 32'(bus.instr_valid), 32'h1);
    check("single_pc",    32'(bus.pc), 32'h02);
    step(0, 0, 0, 8'h00);
    check("single_valid_drop", 32'(bus.instr_valid), 32'h0);

    // back-to-back with fetch_en held
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 9; i++) begin
      step(0, 1, 0, 8'h00);
      check("b2b_valid", 32'(bus.instr_valid), (i % 3 == 2) ? 32'h1 : 32'h0);
    end
    check("b2b_pc",    32'(bus.pc), 32'h06);
    check("b2b_fetch", 32'(bus.Fetch), 32'h2345);

    // redirect during RD_HI
    step(1, 0, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    step(0, 0, 1, 8'h21);
    check("redir_pc",    32'(bus.pc), 32'h20);
    check("redir_valid", 32'(bus.instr_valid), 32'h0);
    check("redir_fetch", 32'(bus.Fetch), 32'hD000);
    check("redir_addr",  32'(bus.rom_addr), 32'h20);
    step(0, 1, 0, 8'h00);
    check("redir_addr_lo", 32'(bus.rom_addr), 32'h21);
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    check("redir_next_fetch", 32'(bus.Fetch), 32'h3C7E);
    check("redir_next_pc",    32'(bus.pc), 32'h22);

    // pc_load beats fetch_en in IDLE
    step(0, 1, 1, 8'h10);
    check("prio_pc",    32'(bus.pc), 32'h10);
    check("prio_state", 32'(state_dbg), 32'(IDLE));
    step(0, 0, 0, 8'h00);
    check("prio_state2", 32'(state_dbg), 32'(IDLE));
    check("prio_valid",  32'(bus.instr_valid), 32'h0);

    // wrap at top of address space
    step(0, 0, 1, 8'hFE);
    step(0, 1, 0, 8'h00);
    check("wrap_addr_lo", 32'(bus.rom_addr), 32'hFF);
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    check("wrap_fetch", 32'(bus.Fetch), 32'h1A5B);
    check("wrap_pc",    32'(bus.pc), 32'h00);

    // reset in the middle of a fetch
    step(0, 1, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    check("midrst_valid", 32'(bus.instr_valid), 32'h0);
    check("midrst_fetch", 32'(bus.Fetch), 32'hD000);
    rom[4] = 8'hD0; rom[5] = 8'h07;
    step(1, 0, 0, 8'h00);

    // HLT
    step(0, 0, 1, 8'h04);
    step(0, 1, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    check("hlt_valid",  32'(bus.instr_valid), 32'h1);
    check("hlt_halted", 32'(bus.halted), 32'h1);
    check("hlt_fetch",  32'(bus.Fetch), 32'hD007);
    check("hlt_state",  32'(state_dbg), 32'(HALTED));
    for (int i = 0; i < 3; i++) step(0, 1, 1, 8'h00);
    check("hlt_pc_hold", 32'(bus.pc), 32'h06);
    check("hlt_addr",    32'(bus.rom_addr), 32'h06);
    check("hlt_novalid", 32'(bus.instr_valid), 32'h0);
    check("hlt_sticky",  32'(bus.halted), 32'h1);
    step(1, 1, 1, 8'h40);
    check("hlt_rst_pc",    32'(bus.pc), 32'h00);
    check("hlt_rst_halt",  32'(bus.halted), 32'h0);
    check("hlt_rst_fetch", 32'(bus.Fetch), 32'hD000);

    // randomized traffic
    randomize_rom();
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 4000; i++) begin
      logic rst_r, fe_r, pl_r;
      rst_r = ($urandom_range(0, 199) == 0) || (m_halted && $urandom_range(0, 7) == 0);
      fe_r  = ($urandom_range(0, 9) < 6);
      pl_r  = ($urandom_range(0, 9) == 0);
      step(rst_r, fe_r, pl_r, 8'($urandom_range(0, 255)));
    end

    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
